mem_wb: RTL and testbench
=========================

MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port clr, input, 1 bit: synchronous flush; drops any writeback not yet driven.
REQ-004 The block SHALL have these upstream inputs: i_valid (1), i_pc (`ADDR_W), i_mem_op (`MEM_OP_W), i_dest_src (`DEST_SRC_W), i_dest_reg (`REG_IDX_W), i_alu_result (`WORD_W), i_store_data (`WORD_W).
REQ-005 The block SHALL have the output o_stall, 1 bit: the upstream holds its inputs while this is high.
REQ-006 The block SHALL have these data memory outputs: o_dmem_req (1), o_dmem_we (1), o_dmem_addr (`ADDR_W), o_dmem_be (4), o_dmem_wdata (`WORD_W).
REQ-007 The block SHALL have these data memory inputs: i_dmem_ack (1) and i_dmem_rdata (`WORD_W).
REQ-008 The block SHALL have these register-file writeback outputs, which feed the decode stage write port: o_wb_dest_en (1), o_wb_dest_reg (`REG_IDX_W), o_wb_dest_data (`WORD_W).

Function
REQ-009 The block SHALL implement three states: IDLE, ACCESS and DONE.
REQ-010 In IDLE with i_valid=1 and o_stall=0, the block SHALL accept the instruction.
REQ-011 If the accepted instruction has i_mem_op=MEM_NOP, the block SHALL stay in IDLE and register a writeback for the next cycle.
REQ-012 For any other i_mem_op, the block SHALL capture the request and move to ACCESS.
REQ-013 The writeback data SHALL be selected by i_dest_src: DEST_SRC_ALU gives i_alu_result, DEST_SRC_PC4 gives i_pc+4 (truncated to `WORD_W), DEST_SRC_MEM gives the aligned load data, and DEST_SRC_NONE gives no writeback.
REQ-014 While in ACCESS, o_dmem_req SHALL be 1, and o_dmem_addr, o_dmem_we, o_dmem_be and o_dmem_wdata SHALL be held stable until i_dmem_ack is sampled high.
REQ-015 o_dmem_addr SHALL be the ALU result with bits [1:0] cleared.
REQ-016 o_dmem_be SHALL be: byte access, 4'b0001<<addr[1:0]; half access, 4'b0011<<addr[1]*2; word access, 4'b1111.
REQ-017 For stores, o_dmem_wdata SHALL be the store data replicated across lanes: the byte 4x, the half 2x, the word as-is.
REQ-018 o_stall SHALL be 1 whenever the state is ACCESS; it SHALL be 0 in IDLE and DONE.
REQ-019 i_dmem_ack SHALL be ignored while o_dmem_req=0.
REQ-020 When i_dmem_ack=1 in ACCESS, the block SHALL go to DONE; for a load, it SHALL latch the selected lane of i_dmem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
REQ-021 In DONE, the block SHALL drive the load writeback for exactly one cycle (stores write nothing), return to IDLE, and be able to accept a new instruction in that same cycle.
REQ-022 Writeback latency SHALL be: non-memory instruction, 1 cycle after acceptance; load, 1 cycle after the ack cycle.
REQ-023 o_wb_dest_en SHALL be a single-cycle pulse per instruction, and SHALL be 0 when i_dest_reg=0 or i_dest_src=DEST_SRC_NONE.
REQ-024 clr in IDLE or DONE SHALL suppress the writeback for that cycle and discard the accepted instruction.
REQ-025 clr in ACCESS SHALL NOT abort the bus request (the transaction completes) but SHALL suppress its writeback.
REQ-026 If clr and i_dmem_ack occur in the same cycle, the block SHALL move to DONE with the writeback suppressed.

Reset
REQ-027 While aresetn=0, the block SHALL force state IDLE, with o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata, o_wb_dest_en, o_wb_dest_reg, o_wb_dest_data and o_stall all 0.
REQ-028 Reset asserted mid-ACCESS SHALL drop the request immediately, and a late ack SHALL then be ignored.

Configuration
REQ-029 With MEM_MISALIGN_TRAP_EN defined, the block SHALL add the output o_misaligned (1).
REQ-030 With MEM_MISALIGN_TRAP_EN defined, a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access SHALL issue no request, do no writeback, and pulse o_misaligned for 1 cycle one cycle after acceptance.
REQ-031 With MEM_MISALIGN_TRAP_EN undefined, the o_misaligned port SHALL be absent, the address low bits SHALL be ignored for half/word access, and lane selection SHALL use aligned lanes.

Verification
REQ-032 The bench SHALL cover: addi, ALU result 0xffffffff, dest x1, dest_src ALU -> next cycle o_wb_dest_en=1, reg=1, data=0xffffffff; o_stall never high.
REQ-033 The bench SHALL cover: LB at addr 0x103, rdata 0x80aabbcc, ack after 3 cycles -> o_dmem_be=4'b1000; o_stall high for 3 cycles; writeback data 0xffffff80.
REQ-034 The bench SHALL cover: SH of 0x1234abcd at 0x202 -> addr 0x200, be=4'b1100, wdata=0xabcdabcd, we=1; no writeback.
REQ-035 The bench SHALL cover: LW at 0x40 with clr asserted in the ack cycle -> request completes, o_wb_dest_en stays 0, then IDLE.
REQ-036 The bench SHALL cover: aresetn pulled low mid-ACCESS -> o_dmem_req=0 at once; a subsequent ack causes no writeback.
REQ-037 The bench SHALL cover: with MEM_MISALIGN_TRAP_EN, LW at 0x41 -> o_misaligned pulses 1 cycle; o_dmem_req stays 0.

Source files
------------

// File: rtl/mem_wb.sv
// mem_wb: memory-access / writeback stage with one outstanding data-bus request at a time.
// Define MEM_MISALIGN_TRAP_EN to add o_misaligned and trap misaligned half/word accesses.
`timescale 1ns/1ps

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef MEM_OP_W
`define MEM_OP_W 4
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LH  4'd2
`define MEM_LW  4'd3
`define MEM_LBU 4'd4
`define MEM_LHU 4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`define DEST_SRC_ALU  2'd1
`define DEST_SRC_PC4  2'd2
`define DEST_SRC_MEM  2'd3
`endif

module mem_wb (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     clr,
    input  logic                     i_valid,
    input  logic [`ADDR_W-1:0]       i_pc,
    input  logic [`MEM_OP_W-1:0]     i_mem_op,
    input  logic [`DEST_SRC_W-1:0]   i_dest_src,
    input  logic [`REG_IDX_W-1:0]    i_dest_reg,
    input  logic [`WORD_W-1:0]       i_alu_result,
    input  logic [`WORD_W-1:0]       i_store_data,
    output logic                     o_stall,
    output logic                     o_dmem_req,
    output logic                     o_dmem_we,
    output logic [`ADDR_W-1:0]       o_dmem_addr,
    output logic [3:0]               o_dmem_be,
    output logic [`WORD_W-1:0]       o_dmem_wdata,
    input  logic                     i_dmem_ack,
    input  logic [`WORD_W-1:0]       i_dmem_rdata,
    output logic                     o_wb_dest_en,
    output logic [`REG_IDX_W-1:0]    o_wb_dest_reg,
    output logic [`WORD_W-1:0]       o_wb_dest_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                     o_misaligned
`endif
);
    localparam int AW = `ADDR_W;
    localparam int WW = `WORD_W;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_N = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q;
    logic                    req_q, we_q, pend_q, supp_q, wb_en_q;
    logic [AW-1:0]           addr_q;
    logic [3:0]              be_q;
    logic [WW-1:0]           wdata_q, wb_data_q;
    logic [`MEM_OP_W-1:0]    op_q;
    logic [1:0]              lane_q;
    logic [`DEST_SRC_W-1:0]  src_q;
    logic [`REG_IDX_W-1:0]   wb_reg_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                    mis_q;
`endif

    logic [1:0]              size_d;
    logic                    load_op_d, store_op_d, writes_d, accept_d, trap_d;
    logic [AW-1:0]           addr_d;
    logic [3:0]              be_d;
    logic [WW-1:0]           wdata_d, nonmem_d, load_d;
    logic [7:0]              lbyte_d;
    logic [15:0]             lhalf_d;

    function automatic logic [1:0] acc_size(input logic [`MEM_OP_W-1:0] op);
        case (op)
            `MEM_LB, `MEM_LBU, `MEM_SB: acc_size = SZ_B;
            `MEM_LH, `MEM_LHU, `MEM_SH: acc_size = SZ_H;
            `MEM_LW, `MEM_SW:           acc_size = SZ_W;
            default:                    acc_size = SZ_N;
        endcase
    endfunction

    always_comb begin
        size_d     = acc_size(i_mem_op);
        load_op_d  = (i_mem_op == `MEM_LB) || (i_mem_op == `MEM_LH) || (i_mem_op == `MEM_LW) ||
                     (i_mem_op == `MEM_LBU) || (i_mem_op == `MEM_LHU);
        store_op_d = (i_mem_op == `MEM_SB) || (i_mem_op == `MEM_SH) || (i_mem_op == `MEM_SW);
        writes_d   = (i_dest_src != `DEST_SRC_NONE) && (i_dest_reg != '0);
        accept_d   = i_valid && !clr && (state_q != ACCESS);
        addr_d     = AW'(i_alu_result);
        addr_d[1:0] = 2'b00;
        case (size_d)
            SZ_B:    be_d = 4'b0001 << i_alu_result[1:0];
            SZ_H:    be_d = i_alu_result[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase
        case (size_d)
            SZ_B:    wdata_d = {(WW/8){i_store_data[7:0]}};
            SZ_H:    wdata_d = {(WW/16){i_store_data[15:0]}};
            default: wdata_d = i_store_data;
        endcase
        case (i_dest_src)
            `DEST_SRC_PC4: nonmem_d = WW'(i_pc + AW'(4));
            default:       nonmem_d = i_alu_result;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_d = ((size_d == SZ_H) && i_alu_result[0]) ||
                    ((size_d == SZ_W) && (i_alu_result[1:0] != 2'b00));
`else
    assign trap_d = 1'b0;
`endif

    // Lane extraction for the captured load, applied to the bus data in the ack cycle.
    always_comb begin
        lbyte_d = i_dmem_rdata[{lane_q, 3'b000} +: 8];
        lhalf_d = lane_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (op_q)
            `MEM_LB:  load_d = {{(WW-8){lbyte_d[7]}}, lbyte_d};
            `MEM_LBU: load_d = {{(WW-8){1'b0}}, lbyte_d};
            `MEM_LH:  load_d = {{(WW-16){lhalf_d[15]}}, lhalf_d};
            `MEM_LHU: load_d = {{(WW-16){1'b0}}, lhalf_d};
            default:  load_d = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            op_q      <= '0;
            lane_q    <= '0;
            src_q     <= '0;
            pend_q    <= 1'b0;
            supp_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            wb_en_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
            case (state_q)
                ACCESS: begin
                    // A flush never aborts the bus cycle; it only cancels the writeback.
                    if (clr) supp_q <= 1'b1;
                    if (i_dmem_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wb_en_q <= pend_q && !supp_q && !clr;
                        if (src_q == `DEST_SRC_MEM) wb_data_q <= load_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (accept_d) begin
                        wb_reg_q  <= i_dest_reg;
                        wb_data_q <= nonmem_d;
                        if (trap_d) begin
`ifdef MEM_MISALIGN_TRAP_EN
                            mis_q <= 1'b1;
`endif
                        end else if (i_mem_op == `MEM_NOP) begin
                            wb_en_q <= writes_d;
                        end else begin
                            state_q <= ACCESS;
                            req_q   <= 1'b1;
                            we_q    <= store_op_d;
                            addr_q  <= addr_d;
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            op_q    <= i_mem_op;
                            lane_q  <= i_alu_result[1:0];
                            src_q   <= i_dest_src;
                            pend_q  <= load_op_d && writes_d;
                            supp_q  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign o_stall        = (state_q == ACCESS);
    assign o_dmem_req     = req_q;
    assign o_dmem_we      = we_q;
    assign o_dmem_addr    = addr_q;
    assign o_dmem_be      = be_q;
    assign o_dmem_wdata   = wdata_q;
    assign o_wb_dest_en   = wb_en_q && !clr;
    assign o_wb_dest_reg  = wb_reg_q;
    assign o_wb_dest_data = wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign o_misaligned   = mis_q;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed and randomized checks of mem_wb against an arithmetic reference model.
// Builds with or without MEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef MEM_OP_W
`define MEM_OP_W 4
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LH  4'd2
`define MEM_LW  4'd3
`define MEM_LBU 4'd4
`define MEM_LHU 4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`define DEST_SRC_ALU  2'd1
`define DEST_SRC_PC4  2'd2
`define DEST_SRC_MEM  2'd3
`endif

module tb_mem_wb;
    logic                    clk = 1'b0;
    logic                    aresetn, clr, i_valid;
    logic [`ADDR_W-1:0]      i_pc;
    logic [`MEM_OP_W-1:0]    i_mem_op;
    logic [`DEST_SRC_W-1:0]  i_dest_src;
    logic [`REG_IDX_W-1:0]   i_dest_reg;
    logic [`WORD_W-1:0]      i_alu_result, i_store_data, i_dmem_rdata;
    logic                    i_dmem_ack;
    logic                    o_stall, o_dmem_req, o_dmem_we, o_wb_dest_en;
    logic [`ADDR_W-1:0]      o_dmem_addr;
    logic [3:0]              o_dmem_be;
    logic [`WORD_W-1:0]      o_dmem_wdata, o_wb_dest_data;
    logic [`REG_IDX_W-1:0]   o_wb_dest_reg;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                    o_misaligned;
`endif

    int vectors = 0;
    int miscompares = 0;

    mem_wb dut (
        .clk(clk), .aresetn(aresetn), .clr(clr), .i_valid(i_valid), .i_pc(i_pc),
        .i_mem_op(i_mem_op), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
        .i_alu_result(i_alu_result), .i_store_data(i_store_data), .o_stall(o_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_wb_dest_en(o_wb_dest_en),
        .o_wb_dest_reg(o_wb_dest_reg), .o_wb_dest_data(o_wb_dest_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .o_misaligned(o_misaligned)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: access size in bytes, byte enables, lane replication and load extension.
    function automatic int sizeOf(input logic [3:0] op);
        if (op == `MEM_LB || op == `MEM_LBU || op == `MEM_SB) return 1;
        if (op == `MEM_LH || op == `MEM_LHU || op == `MEM_SH) return 2;
        if (op == `MEM_LW || op == `MEM_SW) return 4;
        return 0;
    endfunction

    function automatic bit isLoad(input logic [3:0] op);
        return op == `MEM_LB || op == `MEM_LH || op == `MEM_LW || op == `MEM_LBU || op == `MEM_LHU;
    endfunction

    function automatic logic [31:0] expBe(input logic [3:0] op, input logic [31:0] addr);
        int unsigned lane = addr % 4;
        if (sizeOf(op) == 1) return 32'd1 << lane;
        if (sizeOf(op) == 2) return 32'd3 << (2 * (lane / 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] expWdata(input logic [3:0] op, input logic [31:0] sd);
        if (sizeOf(op) == 1) return (sd % 256) * 32'h01010101;
        if (sizeOf(op) == 2) return (sd % 65536) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] expLoad(input logic [3:0] op, input logic [31:0] rdata, input logic [31:0] addr);
        int unsigned v;
        int unsigned lane = addr % 4;
        if (sizeOf(op) == 1) begin
            v = (rdata >> (8 * lane)) % 256;
            if (op == `MEM_LB && v >= 128) v = v - 256;
            return v;
        end
        if (sizeOf(op) == 2) begin
            v = (rdata >> (16 * (lane / 2))) % 65536;
            if (op == `MEM_LH && v >= 32768) v = v - 65536;
            return v;
        end
        return rdata;
    endfunction

    // clrMode: 0 none, 1 clr in ack cycle, 2 clr in DONE, 3 clr in first ACCESS cycle, 4 clr at acceptance.
    task automatic applyStimulus(input logic [3:0] op, input logic [1:0] src, input logic [4:0] dreg,
                                 input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc,
                                 input int ackDelay, input logic [31:0] rdata, input int clrMode);
        bit expEn;
        bit mis = 0;
        logic [31:0] expData;
        int stallCycles = 0;
        i_valid = 1'b1; i_mem_op = op; i_dest_src = src; i_dest_reg = dreg;
        i_alu_result = alu; i_store_data = sd; i_pc = pc; clr = (clrMode == 4);
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (sizeOf(op) == 2 && alu[0]) || (sizeOf(op) == 4 && alu[1:0] != 2'b00);
`endif
        expData = (src == `DEST_SRC_PC4) ? pc + 32'd4 : alu;
        @(posedge clk); @(negedge clk);
        i_valid = 1'b0; clr = 1'b0;
        #1;
        if (clrMode == 4) begin
            checkOutput("clrAcceptWb", o_wb_dest_en, 0);
            checkOutput("clrAcceptReq", o_dmem_req, 0);
            checkOutput("clrAcceptStall", o_stall, 0);
            return;
        end
        if (mis) begin
`ifdef MEM_MISALIGN_TRAP_EN
            checkOutput("misPulse", o_misaligned, 1);
            checkOutput("misReq", o_dmem_req, 0);
            checkOutput("misWb", o_wb_dest_en, 0);
            @(negedge clk); #1;
            checkOutput("misPulseEnd", o_misaligned, 0);
            checkOutput("misReqLater", o_dmem_req, 0);
`endif
            return;
        end
        if (op == `MEM_NOP) begin
            expEn = (src != `DEST_SRC_NONE) && (dreg != 0);
            checkOutput("aluWbEn", o_wb_dest_en, expEn);
            if (expEn) begin
                checkOutput("aluWbReg", o_wb_dest_reg, dreg);
                checkOutput("aluWbData", o_wb_dest_data, expData);
            end
            checkOutput("aluStall", o_stall, 0);
            checkOutput("aluReq", o_dmem_req, 0);
            @(negedge clk); #1;
            checkOutput("aluWbPulse", o_wb_dest_en, 0);
            return;
        end
        checkOutput("memReq", o_dmem_req, 1);
        checkOutput("memAddr", o_dmem_addr, alu & ~32'd3);
        checkOutput("memBe", o_dmem_be, expBe(op, alu));
        checkOutput("memWe", o_dmem_we, !isLoad(op));
        if (!isLoad(op)) checkOutput("memWdata", o_dmem_wdata, expWdata(op, sd));
        for (int c = 1; c <= ackDelay; c++) begin
            if (o_stall) stallCycles++;
            checkOutput("holdReq", o_dmem_req, 1);
            checkOutput("holdAddr", o_dmem_addr, alu & ~32'd3);
            clr = (clrMode == 1 && c == ackDelay) || (clrMode == 3 && c == 1);
            i_dmem_ack = (c == ackDelay);
            i_dmem_rdata = (c == ackDelay) ? rdata : $urandom;
            @(posedge clk); @(negedge clk);
            i_dmem_ack = 1'b0;
            i_dmem_rdata = $urandom;
            clr = (clrMode == 2 && c == ackDelay);
            #1;
        end
        checkOutput("stallCycles", stallCycles, ackDelay);
        checkOutput("doneStall", o_stall, 0);
        checkOutput("doneReq", o_dmem_req, 0);
        expEn = isLoad(op) && (src != `DEST_SRC_NONE) && (dreg != 0) && (clrMode == 0);
        if (src == `DEST_SRC_MEM) expData = expLoad(op, rdata, alu);
        checkOutput("loadWbEn", o_wb_dest_en, expEn);
        if (expEn) begin
            checkOutput("loadWbReg", o_wb_dest_reg, dreg);
            checkOutput("loadWbData", o_wb_dest_data, expData);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        checkOutput("loadWbPulse", o_wb_dest_en, 0);
    endtask

    initial begin
        logic [3:0] op;
        logic [1:0] src;
        int cm;
        aresetn = 1'b0; clr = 1'b0; i_valid = 1'b0; i_pc = '0; i_mem_op = `MEM_NOP;
        i_dest_src = `DEST_SRC_NONE; i_dest_reg = '0; i_alu_result = '0; i_store_data = '0;
        i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstStall", o_stall, 0);
        checkOutput("rstReq", o_dmem_req, 0);
        checkOutput("rstWe", o_dmem_we, 0);
        checkOutput("rstAddr", o_dmem_addr, 0);
        checkOutput("rstBe", o_dmem_be, 0);
        checkOutput("rstWdata", o_dmem_wdata, 0);
        checkOutput("rstWbEn", o_wb_dest_en, 0);
        checkOutput("rstWbReg", o_wb_dest_reg, 0);
        checkOutput("rstWbData", o_wb_dest_data, 0);
        aresetn = 1'b1;
        @(negedge clk); #1;

        applyStimulus(`MEM_NOP, `DEST_SRC_ALU, 5'd1, 32'hffffffff, 32'h0, 32'h1000, 0, 32'h0, 0);
        applyStimulus(`MEM_LB,  `DEST_SRC_MEM, 5'd5, 32'h00000103, 32'h0, 32'h1004, 3, 32'h80aabbcc, 0);
        applyStimulus(`MEM_SH,  `DEST_SRC_NONE, 5'd0, 32'h00000202, 32'h1234abcd, 32'h1008, 2, 32'h0, 0);
        applyStimulus(`MEM_LW,  `DEST_SRC_MEM, 5'd7, 32'h00000040, 32'h0, 32'h100c, 2, 32'hdeadbeef, 1);
        applyStimulus(`MEM_NOP, `DEST_SRC_PC4, 5'd31, 32'h0, 32'h0, 32'hfffffffc, 0, 32'h0, 0);
        applyStimulus(`MEM_NOP, `DEST_SRC_ALU, 5'd0, 32'h12345678, 32'h0, 32'h1010, 0, 32'h0, 0);
        applyStimulus(`MEM_NOP, `DEST_SRC_ALU, 5'd3, 32'h12345678, 32'h0, 32'h1014, 0, 32'h0, 4);
        applyStimulus(`MEM_LH,  `DEST_SRC_MEM, 5'd9, 32'h00000012, 32'h0, 32'h1018, 1, 32'h9abc1234, 2);
        applyStimulus(`MEM_LHU, `DEST_SRC_MEM, 5'd9, 32'h00000012, 32'h0, 32'h101c, 3, 32'h9abc1234, 3);
        applyStimulus(`MEM_LHU, `DEST_SRC_MEM, 5'd10, 32'h00000022, 32'h0, 32'h1020, 1, 32'h9abc1234, 0);
        applyStimulus(`MEM_LBU, `DEST_SRC_MEM, 5'd11, 32'h00000031, 32'h0, 32'h1024, 2, 32'h11228344, 0);

        // Ack with no request outstanding must be ignored.
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hffffffff;
        @(posedge clk); @(negedge clk);
        i_dmem_ack = 1'b0;
        #1;
        checkOutput("strayAckStall", o_stall, 0);
        checkOutput("strayAckWb", o_wb_dest_en, 0);
        checkOutput("strayAckReq", o_dmem_req, 0);

        // Reset in the middle of an access, followed by a late ack.
        i_valid = 1'b1; i_mem_op = `MEM_LW; i_dest_src = `DEST_SRC_MEM; i_dest_reg = 5'd4;
        i_alu_result = 32'h80;
        @(posedge clk); @(negedge clk);
        i_valid = 1'b0;
        #1;
        checkOutput("preRstReq", o_dmem_req, 1);
        #1 aresetn = 1'b0;
        #1;
        checkOutput("midRstReq", o_dmem_req, 0);
        checkOutput("midRstStall", o_stall, 0);
        checkOutput("midRstBe", o_dmem_be, 0);
        @(negedge clk);
        aresetn = 1'b1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h55aa55aa;
        @(posedge clk); @(negedge clk);
        i_dmem_ack = 1'b0;
        #1;
        checkOutput("lateAckWb", o_wb_dest_en, 0);
        checkOutput("lateAckStall", o_stall, 0);
        @(negedge clk); #1;
        checkOutput("lateAckWb2", o_wb_dest_en, 0);
        checkOutput("lateAckReq", o_dmem_req, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        applyStimulus(`MEM_LW, `DEST_SRC_MEM, 5'd6, 32'h00000041, 32'h0, 32'h1030, 1, 32'h0, 0);
`endif

        for (int n = 0; n < 90; n++) begin
            op = 4'($urandom_range(0, 8));
            if (op == `MEM_NOP) src = 2'($urandom_range(0, 2));
            else src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : `DEST_SRC_MEM;
            cm = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 4) : 0;
            applyStimulus(op, src, 5'($urandom_range(0, 31)), $urandom, $urandom,
                          $urandom & 32'hfffffffc, $urandom_range(1, 4), $urandom, cm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
